toggle_bank: RTL and testbench

- Parametrised, N-channel bank of resettable toggle flip-flops. This is the synchronous, multi-channel successor of the single r/t toggle cell.
- Adds selectable modes (edge toggle, level toggle, chained binary counter, hold), per-channel clear, per-channel change strobes and a counter wrap strobe.
- Used wherever the design needs banks of divide-by-2 flags or small event counters in the system clock domain.

---
 rtl/toggle_bank.sv | 67 ++++++
 tb/tb_toggle_bank.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/toggle_bank.sv
// toggle_bank: N-channel bank of synchronous toggle flip-flops with edge,
// level, chained-counter and hold modes, per-channel clear, per-channel
// change strobes and a counter wrap strobe.
module toggle_bank #(
  parameter int             N         = 8,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         r,
  input  logic [1:0]   mode,
  input  logic [N-1:0] t,
  input  logic [N-1:0] clr,
  output logic [N-1:0] q,
  output logic [N-1:0] chg,
  output logic         wrap
);

  localparam logic [1:0] MODE_EDGE  = 2'd0;
  localparam logic [1:0] MODE_LEVEL = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_HOLD  = 2'd3;

  logic [N-1:0] t_d;
  logic [N-1:0] rise;
  logic [N-1:0] q_n;
  logic [N-1:0] q_clr;
  logic         wrap_n;

  // Rising-edge detect of each toggle request against the previous cycle.
  assign rise = t & ~t_d;

  // Per-mode next state; clear is applied afterwards so carries still ripple.
  always_comb begin
    q_n = q;
    unique case (mode)
      MODE_EDGE:  q_n = q ^ rise;
      MODE_LEVEL: q_n = q ^ t;
      MODE_COUNT: q_n = rise[0] ? q + {{(N-1){1'b0}}, 1'b1} : q;
      MODE_HOLD:  q_n = q;
      default:    q_n = q;
    endcase
  end

  assign q_clr  = q_n & ~clr;
  // Rollover is flagged from the increment itself, even if clr masks it.
  assign wrap_n = (mode == MODE_COUNT) && rise[0] && (&q);

  // Edge-detect history follows t unconditionally, including reset and hold,
  // so a level already high at reset release or mode switch never toggles.
  always_ff @(posedge clk) begin
    t_d <= t;
  end

  // Channel state and strobes; reset wins over clear, clear over toggle.
  always_ff @(posedge clk) begin
    if (r) begin
      q    <= RESET_VAL;
      chg  <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_clr;
      chg  <= q ^ q_clr;
      wrap <= wrap_n;
    end
  end

endmodule

// File: tb/tb_toggle_bank.sv
// Directed bench for toggle_bank (N=8) with a reference model feeding an
// expected-result queue that is drained one entry per clock.
module tb_toggle_bank;

  localparam int          N  = 8;
  localparam logic [7:0]  RV = 8'h00;

  logic         clk = 1'b0;
  logic         r;
  logic [1:0]   mode;
  logic [N-1:0] t;
  logic [N-1:0] clr;
  logic [N-1:0] q;
  logic [N-1:0] chg;
  logic         wrap;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] chg;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [7:0] mq;
  logic [7:0] mtd;
  int checks = 0;
  int fails  = 0;

  toggle_bank #(.N(N), .RESET_VAL(RV)) dut (
    .clk(clk), .r(r), .mode(mode), .t(t), .clr(clr),
    .q(q), .chg(chg), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction, compare after the edge.
  task automatic step(input string tag, input logic rr, input logic [1:0] mm,
                      input logic [7:0] tt, input logic [7:0] cc);
    logic [7:0] rise, qn, nq, ec;
    logic       ew;
    exp_t       p;
    r = rr; mode = mm; t = tt; clr = cc;
    rise = tt & ~mtd;
    case (mm)
      2'd0:    qn = mq ^ rise;
      2'd1:    qn = mq ^ tt;
      2'd2:    qn = rise[0] ? mq + 8'd1 : mq;
      default: qn = mq;
    endcase
    if (rr) begin
      nq = RV; ec = 8'h00; ew = 1'b0;
    end else begin
      nq = qn & ~cc;
      ec = mq ^ nq;
      ew = (mm == 2'd2) && rise[0] && (mq == 8'hFF);
    end
    mtd = tt;
    mq  = nq;
    p.q = nq; p.chg = ec; p.wrap = ew;
    sb.push_back(p);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk8({tag, " q"},    q,    e.q);
    chk8({tag, " chg"},  chg,  e.chg);
    chk1({tag, " wrap"}, wrap, e.wrap);
  endtask

  initial begin
    mq = 8'h00; mtd = 8'h00;
    r = 1'b1; mode = 2'd0; t = 8'h00; clr = 8'h00;
    @(posedge clk); #1;

    // Reset held with t high, then release with t still high.
    step("rst", 1'b1, 2'd0, 8'hFF, 8'h00);
    step("rst", 1'b1, 2'd0, 8'hFF, 8'h00);
    chk8("rst q const", q, 8'h00);
    for (int i = 0; i < 5; i++) step("rst_rel", 1'b0, 2'd0, 8'hFF, 8'h00);
    chk8("rst_rel q const", q, 8'h00);
    chk8("rst_rel chg const", chg, 8'h00);

    // Edge toggle on t[3].
    step("edge_low", 1'b0, 2'd0, 8'h00, 8'h00);
    step("edge_rise1", 1'b0, 2'd0, 8'h08, 8'h00);
    chk8("edge_rise1 q const", q, 8'h08);
    chk8("edge_rise1 chg const", chg, 8'h08);
    for (int i = 0; i < 4; i++) step("edge_hold", 1'b0, 2'd0, 8'h08, 8'h00);
    chk8("edge_hold chg const", chg, 8'h00);
    step("edge_low2", 1'b0, 2'd0, 8'h00, 8'h00);
    step("edge_low2", 1'b0, 2'd0, 8'h00, 8'h00);
    step("edge_rise2", 1'b0, 2'd0, 8'h08, 8'h00);
    chk8("edge_rise2 q const", q, 8'h00);

    // Level toggle on t[0] for three cycles.
    step("lvl1", 1'b0, 2'd1, 8'h01, 8'h00);
    chk8("lvl1 q const", q, 8'h01);
    step("lvl2", 1'b0, 2'd1, 8'h01, 8'h00);
    chk8("lvl2 q const", q, 8'h00);
    step("lvl3", 1'b0, 2'd1, 8'h01, 8'h00);
    chk8("lvl3 q const", q, 8'h01);
    chk8("lvl3 chg const", chg, 8'h01);
    step("lvl_off", 1'b0, 2'd1, 8'h00, 8'h00);

    // Chained counter: 256 isolated edges on t[0], upper bits random.
    step("cnt_rst", 1'b1, 2'd2, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) begin
      step("cnt_rise", 1'b0, 2'd2, {7'($urandom), 1'b1}, 8'h00);
      chk8("cnt_seq", q, 8'(i + 1));
      step("cnt_fall", 1'b0, 2'd2, {7'($urandom), 1'b0}, 8'h00);
    end
    step("cnt_idle", 1'b0, 2'd2, 8'h00, 8'h00);
    step("cnt_wrap", 1'b0, 2'd2, 8'h01, 8'h00);
    chk1("cnt_wrap wrap const", wrap, 1'b0);
    for (int i = 0; i < 254; i++) begin
      step("cnt_fill", 1'b0, 2'd2, 8'h00, 8'h00);
      step("cnt_fill", 1'b0, 2'd2, 8'h01, 8'h00);
    end
    chk8("cnt_full q const", q, 8'hFF);
    step("cnt_fall", 1'b0, 2'd2, 8'h00, 8'h00);
    step("cnt_roll", 1'b0, 2'd2, 8'h01, 8'h00);
    chk8("cnt_roll q const", q, 8'h00);
    chk8("cnt_roll chg const", chg, 8'hFF);
    chk1("cnt_roll wrap const", wrap, 1'b1);
    step("cnt_after", 1'b0, 2'd2, 8'h00, 8'h00);
    chk1("cnt_after wrap const", wrap, 1'b0);

    // Counter rollover with clr masking the result still flags wrap.
    step("cntc_rst", 1'b1, 2'd1, 8'h00, 8'h00);
    step("cntc_set", 1'b0, 2'd1, 8'hFF, 8'h00);
    step("cntc_low", 1'b0, 2'd2, 8'h00, 8'h00);
    step("cntc_roll", 1'b0, 2'd2, 8'h01, 8'hF0);

    // Priority: clr over toggle, then reset over everything.
    step("pri_rst", 1'b1, 2'd0, 8'h00, 8'h00);
    step("pri_set", 1'b0, 2'd1, 8'h0F, 8'h00);
    step("pri_low", 1'b0, 2'd0, 8'h00, 8'h00);
    chk8("pri_low q const", q, 8'h0F);
    step("pri_clr", 1'b0, 2'd0, 8'h01, 8'h01);
    chk8("pri_clr q const", q, 8'h0E);
    chk8("pri_clr chg const", chg, 8'h01);
    step("pri_r", 1'b1, 2'd0, 8'h03, 8'h04);
    chk8("pri_r q const", q, RV);
    chk8("pri_r chg const", chg, 8'h00);

    // Hold mode, then switch to edge mode with t already high.
    step("hold_set", 1'b0, 2'd1, 8'h21, 8'h00);
    step("hold_a", 1'b0, 2'd3, 8'h00, 8'h00);
    step("hold_b", 1'b0, 2'd3, 8'hFF, 8'h00);
    step("hold_c", 1'b0, 2'd3, 8'h00, 8'h00);
    step("hold_d", 1'b0, 2'd3, 8'hFF, 8'h00);
    chk8("hold q const", q, 8'h21);
    chk8("hold chg const", chg, 8'h00);
    step("sw_edge", 1'b0, 2'd0, 8'hFF, 8'h00);
    chk8("sw_edge q const", q, 8'h21);
    step("sw_low5", 1'b0, 2'd0, 8'hDF, 8'h00);
    step("sw_rise5", 1'b0, 2'd0, 8'hFF, 8'h00);
    chk8("sw_rise5 q const", q, 8'h01);
    chk8("sw_rise5 chg const", chg, 8'h20);

    checks++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain: got %0d expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
